// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode enum for the parametrised FIFO.
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Pointer and count share one width: they must represent 0..DEPTH inclusive.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer handshake and status bundle for fifo_param.
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    import fifo_pkg::*;

    localparam int CNT_W = cnt_w(DEPTH);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, rd, data_in,
        input  data_out, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, data_in,
        output data_out, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clock,
    input  logic                      we_i,
    input  logic [addr_w(DEPTH)-1:0]  waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [addr_w(DEPTH)-1:0]  raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with fill level, threshold flags, error pulses
// and an optional first-word-fall-through read port.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic         clock,
    input  logic         rst,
    fifo_param_if.slave  bus
);

    localparam int PTR_W  = fifo_pkg::ptr_w(DEPTH);
    localparam int ADDR_W = fifo_pkg::addr_w(DEPTH);
    localparam int CNT_W  = fifo_pkg::cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic             AF_RST  = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

    localparam fifo_pkg::fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic             af_q,     af_d;
    logic             ae_q,     ae_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic [WIDTH-1:0] dout_q,   dout_d;

    logic             wr_ok_s;
    logic             rd_ok_s;
    logic [WIDTH-1:0] mem_rdata_s;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .we_i    (wr_ok_s),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata_s)
    );

    // Acceptance, next pointers/count and flags computed from the next count.
    always_comb begin
        wr_ok_s  = 1'b0;
        rd_ok_s  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        // A read on a full FIFO frees the slot the simultaneous write fills.
        wr_ok_s = bus.wr && (!full_q || bus.rd);
        rd_ok_s = bus.rd && !empty_q;

        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = mem_rdata_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = bus.wr && !wr_ok_s;
        unf_d   = bus.rd && !rd_ok_s;
    end

    // State register with synchronous reset; rst overrides any request.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= AF_RST;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.data_out     = (MODE == fifo_pkg::FWFT) ? (empty_q ? '0 : mem_rdata_s) : dout_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed plus random checks of fifo_param in standard and FWFT modes against a queue model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst_v = 1'b1;
    logic       wr_v = 1'b0;
    logic       rd_v = 1'b0;
    logic [7:0] din_v = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] q [$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       prev_full = 1'b0;
    int         full_rises = 0;

    always #5 clk = ~clk;

    fifo_param_if #(.WIDTH(8), .DEPTH(16)) if_s ();
    fifo_param_if #(.WIDTH(8), .DEPTH(16)) if_f ();

    assign if_s.wr = wr_v;
    assign if_s.rd = rd_v;
    assign if_s.data_in = din_v;
    assign if_f.wr = wr_v;
    assign if_f.rd = rd_v;
    assign if_f.data_in = din_v;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clock (clk),
        .rst   (rst_v),
        .bus   (if_s.slave)
    );

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clock (clk),
        .rst   (rst_v),
        .bus   (if_f.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [7:0] f_exp;
        n = q.size();
        f_exp = (n == 0) ? 8'h00 : q[0];
        chk("count",        32'(if_s.count),        32'(n));
        chk("empty",        32'(if_s.empty),        32'(n == 0));
        chk("full",         32'(if_s.full),         32'(n == 16));
        chk("almost_full",  32'(if_s.almost_full),  32'(n >= 14));
        chk("almost_empty", 32'(if_s.almost_empty), 32'(n <= 2));
        chk("overflow",     32'(if_s.overflow),     32'(m_ovf));
        chk("underflow",    32'(if_s.underflow),    32'(m_unf));
        chk("std_dout",     32'(if_s.data_out),     32'(m_dout));
        chk("fwft_count",   32'(if_f.count),        32'(n));
        chk("fwft_uflow",   32'(if_f.underflow),    32'(m_unf));
        chk("fwft_dout",    32'(if_f.data_out),     32'(f_exp));
    endtask

    // One clock: drive, update reference at the edge, check 1 time unit later.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        int  n;
        logic wacc;
        logic racc;
        wr_v = w;
        rd_v = r;
        din_v = d;
        rst_v = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n = q.size();
            wacc = w && ((n < 16) || r);
            racc = r && (n > 0);
            m_ovf = w && !wacc;
            m_unf = r && !racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(d);
        end
        #1;
        check_all();
        if (if_s.full && !prev_full) full_rises++;
        prev_full = if_s.full;
    endtask

    initial begin
        logic [7:0] v;

        // Reset then idle.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset_dout", 32'(if_s.data_out), 32'h0);

        // Fill 0x00..0x0F, watch thresholds.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            chk("af_edge", 32'(if_s.almost_full), 32'(i + 1 >= 14));
        end
        chk("full_at_16", 32'(if_s.full), 32'h1);

        // 17th write rejected, overflow for exactly one cycle.
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(if_s.overflow), 32'h1);
        chk("ovf_count", 32'(if_s.count), 32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(if_s.overflow), 32'h0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_order", 32'(if_s.data_out), 32'(i));
        end

        // Read on empty: underflow, data_out held.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("uflow_pulse", 32'(if_s.underflow), 32'h1);
        chk("uflow_hold", 32'(if_s.data_out), 32'h0F);

        // Write+read on empty: write lands, read rejected.
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("wr_rd_empty_cnt", 32'(if_s.count), 32'd1);
        chk("wr_rd_empty_uf", 32'(if_s.underflow), 32'h1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wr_rd_empty_data", 32'(if_s.data_out), 32'h77);

        // Wrap-around across the pointer boundary.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        full_rises = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("wrap_order", 32'(if_s.data_out), 32'(8'h20 + i));
        end
        chk("wrap_full_once", 32'(full_rises), 32'd1);

        // Simultaneous write+read while full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("full_wr_rd_cnt", 32'(if_s.count), 32'd16);
        chk("full_wr_rd_ovf", 32'(if_s.overflow), 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("full_wr_rd_last", 32'(if_s.data_out), 32'h55);

        // FWFT: fall-through, pop, reset mid-stream.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        chk("fwft_first", 32'(if_f.data_out), 32'h11);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("fwft_pop", 32'(if_f.data_out), 32'h22);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        chk("fwft_rst_empty", 32'(if_f.empty), 32'h1);
        chk("fwft_rst_dout", 32'(if_f.data_out), 32'h0);

        // Random traffic, with rare resets.
        for (int i = 0; i < 400; i++) begin
            v = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v,
                 ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous single-clock FIFO: the successor to the fixed 8-bit `fifo`. It adds configurable width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It is driven by the existing class-based generator/driver/monitor/scoreboard environment through an extended interface.

## Interface
Parameters:
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AF_LEVEL`, default DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- `FWFT`, default 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- One clock; reset is synchronous and active-high.
- `clock` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr` in 1: write request.
- `rd` in 1: read request (standard mode) or pop (FWFT mode).
- `data_in` in WIDTH: write data.
- `data_out` out WIDTH: read data.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `almost_full` out 1: count ≥ AF_LEVEL.
- `almost_empty` out 1: count ≤ AE_LEVEL.
- `count` out $clog2(DEPTH)+1: number of stored words, 0..DEPTH.
- `overflow` out 1: one-cycle pulse; a write was rejected.
- `underflow` out 1: one-cycle pulse; a read was rejected.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide.
  - Address = low bits; wrap-around is natural modulo DEPTH.
  - Full = low bits equal and MSB differs; empty = pointers equal.
- Write accepted iff `wr && (!full || rd)`. Accepted write stores `data_in` at `wr_ptr` and increments `wr_ptr`.
- Read accepted iff `rd && !empty`. Accepted read increments `rd_ptr`.
- Simultaneous read and write:
  - Both accepted: count unchanged. This includes the full case, where the read frees the slot the write fills.
  - When empty: the write is accepted and the read is rejected, pulsing `underflow`. There is no write-to-read bypass.
- Rejected write: memory and pointers unchanged; `overflow`=1 for the following cycle only.
- Rejected read: `rd_ptr` and `data_out` unchanged; `underflow`=1 for the following cycle only.
- Standard mode (FWFT=0): on an accepted read, `data_out` is loaded with mem[rd_ptr] and held until the next accepted read.
- FWFT mode (FWFT=1):
  - `data_out` = mem[rd_ptr] combinationally whenever !empty; `rd` acknowledges and pops that word.
  - `data_out` = 0 while empty.
- `count` increments on a write-only cycle, decrements on a read-only cycle, and is unchanged otherwise.
- All status flags are registered and derived from the next-state count, so they are consistent with `count` in every cycle.
- Reset values: pointers 0, `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=(AF_LEVEL==0 ? 1 : 0) (always 0 in the legal range), `overflow`=0, `underflow`=0, `data_out`=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored words. `rst` takes priority over `wr`/`rd` in the same cycle.

## Timing
- Write at edge N: `empty` falls and `count` increments, visible after edge N.
- Standard read at edge M: new `data_out` is valid after edge M (one-cycle read latency).
- FWFT: the first word appears on `data_out` in the cycle after its write edge; a pop at edge M presents the next word after edge M.
- `full` rises after the edge that stores word DEPTH. A write in that same cycle is evaluated against the pre-edge `full`=0.
- `overflow`/`underflow` are high for exactly one cycle, starting after the offending edge.

## Structure
- Package `fifo_pkg`: `localparam`-style helpers for pointer width `PTR_W = $clog2(DEPTH)+1` and count width, plus the enum `fifo_mode_e {STD, FWFT}`.
- Sub-module `fifo_mem`: DEPTH×WIDTH RAM with synchronous write and asynchronous read, no reset.
- Top level contains pointers, count, flags, error pulses, and the output register/mux.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- Reset then idle: `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, no error pulses.
- Fill with 0x00..0x0F:
  - `almost_full` rises at count 14; `full` at 16.
  - A 17th write of 0xAA pulses `overflow` once; `count` stays 16.
  - Draining reads return 0x00..0x0F in order.
- Wrap-around: write 10, read 10, write 16 words 0x20..0x2F, read 16. Data is returned in order across the pointer wrap, and `full` asserts exactly once.
- While full, assert `wr` and `rd` together with data_in=0x55: both accepted, `count` stays 16, and 0x55 is read out last.
- While empty:
  - `rd` alone pulses `underflow` and `data_out` is unchanged.
  - `wr`+`rd` with 0x77: `count`=1 and `underflow` pulses.
- FWFT=1:
  - Write 0x11 then 0x22: `data_out`=0x11 one cycle after the first write with no `rd`.
  - A pop shows 0x22.
  - Asserting `rst` mid-stream gives `empty`=1 and `data_out`=0 on the next cycle.
